bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 16, max consecutive grant cycles before forced release (timeout build only).
REQ-002 SHALL have parameter PRIO_RR, default 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins).
REQ-003 clk  input  1  single system clock, all state rising-edge.
REQ-004 clr  input  1  reset, asynchronous, active-high.
REQ-005 req  input  32  per-source bus-drive request; bit n = bus source code n.
REQ-006 gnt  output  32  one-hot grant, registered.
REQ-007 sel  output  5  binary code of granted source, registered, drives bus mux select.
REQ-008 bus_busy  output  1  high while any grant is active.
REQ-009 timeout  output  1  one-cycle pulse on forced release (timeout build only, else tied 0).

Function
REQ-010 Legal sources SHALL be codes 0-19, 21, 22, 23 and 25 (VALID_MASK); req bits outside VALID_MASK SHALL be ignored.
REQ-011 FSM SHALL have three states: IDLE, OWN, TURN.
REQ-012 IDLE: if any masked req is high, SHALL select a winner, enter OWN next edge with gnt/sel set; else stay IDLE.
REQ-013 Grant latency SHALL be exactly one cycle from req sampled high in IDLE to gnt high.
REQ-014 OWN: grant SHALL hold unchanged while the owner's req stays high; other requests SHALL NOT pre-empt.
REQ-015 OWN: owner req low SHALL clear gnt/sel-valid next edge and enter TURN.
REQ-016 TURN SHALL last exactly one cycle with gnt = 0 (dead cycle against bus contention), then return to IDLE.
REQ-017 Minimum spacing between two different grants SHALL therefore be two cycles of gnt = 0... specifically one TURN cycle plus one IDLE arbitration cycle.
REQ-018 Round-robin: search SHALL start at index (last_owner + 1) mod 32 and wrap from 31 to 0; last_owner SHALL update only on grant.
REQ-019 Fixed priority: lowest set masked index SHALL win.
REQ-020 gnt SHALL always be zero or one-hot; sel SHALL equal index of the set gnt bit, and 5'b00000 when gnt = 0.
REQ-021 bus_busy SHALL equal |gnt.
REQ-022 Owner dropping and re-raising req in consecutive cycles SHALL still pass through TURN and re-arbitrate.
REQ-023 Simultaneous requests in IDLE SHALL resolve in a single cycle per REQ-018/019.

Reset
REQ-024 clr high SHALL immediately force state IDLE, gnt = 0, sel = 0, bus_busy = 0, timeout = 0, last_owner = 31, hold counter = 0.
REQ-025 clr asserted during OWN SHALL drop the grant asynchronously; no TURN cycle follows.
REQ-026 After clr deasserts, first arbitration SHALL occur at the first clk edge, round-robin starting at index 0.

Configuration
REQ-027 Macro BUS_ARB_TIMEOUT_EN defined: a hold counter SHALL count OWN cycles; on reaching MAX_HOLD the grant SHALL be revoked, timeout pulses one cycle, FSM enters TURN, and that owner SHALL be skipped until its req deasserts once.
REQ-028 Macro undefined: no counter, grant held indefinitely, timeout tied 0.

Structure
REQ-029 Shared package bus_arb_pkg SHALL hold the state enum, source code constants (R0..R15, HI=16, LO=17, ZHI=18, ZLO=19, PC=21, MDR=22, INPORT=23, C=25) and VALID_MASK.
REQ-030 Winner selection SHALL be a sub-module rr_pick (masked request, start index -> one-hot winner plus code), combinational.

Verification
REQ-031 clr, then req = 32'h0000_0004 -> gnt = 32'h4, sel = 5'd2 one cycle later; bus_busy = 1.
REQ-032 req = 32'h0020_0001 held by both, owner 0 drops after 3 cycles -> TURN (gnt = 0), IDLE, then gnt = 32'h0020_0000, sel = 5'd21.
REQ-033 req = 32'h0010_0000 (code 20, illegal) alone -> gnt stays 0, bus_busy = 0.
REQ-034 Round-robin wrap: last owner 25, req = 32'h0200_0001 -> next grant sel = 0, not 25.
REQ-035 clr pulsed mid-OWN with sel = 5'd22 -> gnt = 0, sel = 0 asynchronously, no TURN.
REQ-036 BUS_ARB_TIMEOUT_EN, MAX_HOLD = 4, req bit 16 held -> grant for 4 cycles, timeout pulse, bit 16 not regranted until req toggles low.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared types and source codes for the bus arbiter.
// Legal bus sources are collected in VALID_MASK.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    TURN
  } state_t;

  localparam logic [4:0] R0  = 5'd0;
  localparam logic [4:0] R1  = 5'd1;
  localparam logic [4:0] R2  = 5'd2;
  localparam logic [4:0] R3  = 5'd3;
  localparam logic [4:0] R4  = 5'd4;
  localparam logic [4:0] R5  = 5'd5;
  localparam logic [4:0] R6  = 5'd6;
  localparam logic [4:0] R7  = 5'd7;
  localparam logic [4:0] R8  = 5'd8;
  localparam logic [4:0] R9  = 5'd9;
  localparam logic [4:0] R10 = 5'd10;
  localparam logic [4:0] R11 = 5'd11;
  localparam logic [4:0] R12 = 5'd12;
  localparam logic [4:0] R13 = 5'd13;
  localparam logic [4:0] R14 = 5'd14;
  localparam logic [4:0] R15 = 5'd15;
  localparam logic [4:0] HI     = 5'd16;
  localparam logic [4:0] LO     = 5'd17;
  localparam logic [4:0] ZHI    = 5'd18;
  localparam logic [4:0] ZLO    = 5'd19;
  localparam logic [4:0] PC     = 5'd21;
  localparam logic [4:0] MDR    = 5'd22;
  localparam logic [4:0] INPORT = 5'd23;
  localparam logic [4:0] C      = 5'd25;

  // codes 0-19, 21-23, 25
  localparam logic [31:0] VALID_MASK = 32'h02EF_FFFF;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational winner search: first set bit of mreq
// at or after start, wrapping from 31 to 0.
module rr_pick (
  input  logic [31:0] mreq,
  input  logic [4:0]  start,
  output logic [31:0] win_oh,
  output logic [4:0]  win_code,
  output logic        found
);

  logic [4:0] idx;

  always_comb begin
    win_oh   = '0;
    win_code = '0;
    found    = 1'b0;
    idx      = '0;
    for (int i = 0; i < 32; i++) begin
      idx = start + 5'(i);
      if (!found && mreq[idx]) begin
        found       = 1'b1;
        win_code    = idx;
        win_oh[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Three-state bus arbiter with a dead TURN cycle between owners.
// Define BUS_ARB_TIMEOUT_EN to enable the MAX_HOLD forced release.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int PRIO_RR  = 1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] req,
  output logic [31:0] gnt,
  output logic [4:0]  sel,
  output logic        bus_busy,
  output logic        timeout
);

  state_t      state, state_nx;
  logic [31:0] gnt_nx, mreq, win_oh;
  logic [4:0]  sel_nx, last, last_nx;
  logic [4:0]  start, win_code;
  logic        found, drop, expire;

  assign start = (PRIO_RR != 0) ? last + 5'd1 : 5'd0;
  assign drop  = !req[sel];

  rr_pick u_pick (
    .mreq     (mreq),
    .start    (start),
    .win_oh   (win_oh),
    .win_code (win_code),
    .found    (found)
  );

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);

  logic [HW-1:0] hold, hold_nx;
  logic [4:0]    skip, skip_nx;
  logic          skip_v, skip_v_nx;
  logic          to_q, to_nx;

  assign expire = (state == OWN) && !drop &&
                  (hold == HW'(MAX_HOLD));
  // a timed-out owner sits out until it lets go once
  assign mreq = req & VALID_MASK &
                ~(32'(skip_v) << skip);
  assign timeout = to_q;

  always_comb begin
    hold_nx   = '0;
    to_nx     = 1'b0;
    skip_v_nx = skip_v;
    skip_nx   = skip;
    if (skip_v && !req[skip])
      skip_v_nx = 1'b0;
    if (state == IDLE && found)
      hold_nx = HW'(1);
    else if (state == OWN && !drop && !expire)
      hold_nx = hold + 1'b1;
    if (expire) begin
      to_nx     = 1'b1;
      skip_v_nx = 1'b1;
      skip_nx   = sel;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      hold   <= '0;
      to_q   <= 1'b0;
      skip_v <= 1'b0;
      skip   <= '0;
    end else begin
      hold   <= hold_nx;
      to_q   <= to_nx;
      skip_v <= skip_v_nx;
      skip   <= skip_nx;
    end
  end
`else
  logic unused_hold;

  assign unused_hold = (MAX_HOLD > 0);
  assign expire      = 1'b0;
  assign mreq        = req & VALID_MASK;
  assign timeout     = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    sel_nx   = sel;
    last_nx  = last;
    unique case (state)
      IDLE: if (found) begin
        state_nx = OWN;
        gnt_nx   = win_oh;
        sel_nx   = win_code;
        last_nx  = win_code;
      end
      OWN: if (drop || expire) begin
        state_nx = TURN;
        gnt_nx   = '0;
        sel_nx   = '0;
      end
      TURN:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      gnt   <= '0;
      sel   <= '0;
      last  <= 5'd31;
    end else begin
      state <= state_nx;
      gnt   <= gnt_nx;
      sel   <= sel_nx;
      last  <= last_nx;
    end
  end

  assign bus_busy = |gnt;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed and random checks of bus_arbiter against
// a behavioural arbitration model.
module tb_bus_arbiter;

  localparam int MAXH = 4;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] req;
  logic [31:0] gnt;
  logic [4:0]  sel;
  logic        bus_busy;
  logic        timeout;

  int total = 0;
  int bad   = 0;

  // model: phase 0 idle, 1 owned, 2 turn
  int m_phase, m_owner, m_last, m_hold, m_skip;
  bit m_to;

  always #5 clk = ~clk;

  bus_arbiter #(
    .MAX_HOLD (MAXH),
    .PRIO_RR  (1)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .req      (req),
    .gnt      (gnt),
    .sel      (sel),
    .bus_busy (bus_busy),
    .timeout  (timeout)
  );

  function automatic bit legal(int c);
    return (c <= 19) || (c == 21) || (c == 22) ||
           (c == 23) || (c == 25);
  endfunction

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_owner = -1;
    m_last  = 31;
    m_hold  = 0;
    m_skip  = -1;
    m_to    = 1'b0;
  endtask

  task automatic model_step(logic [31:0] r);
    int idx;
    int to_src;
    to_src = -1;
    m_to   = 1'b0;
    case (m_phase)
      0: begin
        for (int k = 0; k < 32; k++) begin
          idx = (m_last + 1 + k) % 32;
          if (m_owner < 0 && r[idx] && legal(idx) &&
              idx != m_skip) begin
            m_owner = idx;
            m_last  = idx;
            m_hold  = 1;
            m_phase = 1;
          end
        end
      end
      1: begin
        if (!r[m_owner]) begin
          m_phase = 2;
          m_owner = -1;
        end else if (TO && m_hold == MAXH) begin
          m_phase = 2;
          m_to    = 1'b1;
          to_src  = m_owner;
          m_owner = -1;
        end else begin
          m_hold++;
        end
      end
      default: m_phase = 0;
    endcase
    if (m_skip >= 0 && !r[m_skip]) m_skip = -1;
    if (to_src >= 0) m_skip = to_src;
  endtask

  task automatic check_outs(string tag);
    logic [31:0] eg;
    logic [4:0]  es;
    eg = (m_owner >= 0) ? (32'h1 << m_owner) : 32'h0;
    es = (m_owner >= 0) ? 5'(m_owner) : 5'd0;
    chk({tag, ".gnt"}, gnt, eg);
    chk({tag, ".sel"}, 32'(sel), 32'(es));
    chk({tag, ".busy"}, 32'(bus_busy), 32'(eg != 0));
    chk({tag, ".to"}, 32'(timeout), 32'(m_to));
    chk({tag, ".onehot"},
        32'($countones(gnt) <= 1), 32'd1);
  endtask

  task automatic step(string tag, logic [31:0] r);
    req = r;
    @(posedge clk);
    model_step(r);
    #1;
    check_outs(tag);
  endtask

  // asserted between edges so the clear is seen asynchronously
  task automatic pulse_clr(string tag);
    clr = 1'b1;
    #1;
    model_reset();
    check_outs(tag);
    #2;
    clr = 1'b0;
  endtask

  initial begin
    int hits;
    logic [31:0] r;
    clr = 1'b1;
    req = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset");
    #2;
    clr = 1'b0;

    step("r31", 32'h0000_0004);
    chk("r31.gnt4", gnt, 32'h4);
    chk("r31.sel2", 32'(sel), 32'd2);
    chk("r31.busy", 32'(bus_busy), 32'd1);
    step("r31.drop", 32'h0);
    step("r31.idle", 32'h0);

    pulse_clr("clr1");
    step("r32.a", 32'h0020_0001);
    chk("r32.own0", gnt, 32'h1);
    step("r32.b", 32'h0020_0001);
    step("r32.c", 32'h0020_0001);
    step("r32.turn", 32'h0020_0000);
    chk("r32.turn0", gnt, 32'h0);
    step("r32.idle", 32'h0020_0000);
    chk("r32.idle0", gnt, 32'h0);
    step("r32.win", 32'h0020_0000);
    chk("r32.gnt21", gnt, 32'h0020_0000);
    chk("r32.sel21", 32'(sel), 32'd21);

    pulse_clr("clr2");
    repeat (3) step("r33", 32'h0010_0000);
    chk("r33.busy0", 32'(bus_busy), 32'd0);

    pulse_clr("clr3");
    step("r34.own25", 32'h0200_0000);
    step("r34.turn", 32'h0);
    step("r34.idle", 32'h0);
    step("r34.wrap", 32'h0200_0001);
    chk("r34.sel0", 32'(sel), 32'd0);

    pulse_clr("clr4");
    step("r35.own22", 32'h0040_0000);
    chk("r35.sel22", 32'(sel), 32'd22);
    pulse_clr("r35.clr");
    chk("r35.gnt0", gnt, 32'h0);
    step("r35.regrant", 32'h0040_0000);
    chk("r35.noturn", gnt, 32'h0040_0000);

    pulse_clr("clr5");
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      step("r36.hold", 32'h0001_0000);
      if (gnt == 32'h0001_0000) hits++;
    end
    chk("r36.cycles", 32'(hits), TO ? 32'd4 : 32'd8);
    step("r36.low", 32'h0);
    for (int i = 0; i < 3; i++)
      step("r36.again", 32'h0001_0000);
    chk("r36.regrant", gnt, 32'h0001_0000);

    pulse_clr("clr6");
    r = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(2) == 0)
        r = $urandom & $urandom & $urandom;
      if ($urandom_range(7) == 0 && m_owner >= 0)
        r[m_owner] = 1'b0;
      step("rand", r);
      if ($urandom_range(59) == 0)
        pulse_clr("rand.clr");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
